fproc_arbiter: RTL and testbench

- Shares one function-processor (fproc) backend among N_CORES processor cores.
- Each core's controller pulses fproc_out_ready for one cycle when it decodes an fproc-type instruction, then stalls until its fproc_ready pulse returns.
- This block latches those pulses and grants the backend round-robin, one transaction at a time.
- It returns the backend's response, or a timeout error, to the requesting core.

---
 rtl/fproc_arb_pkg.sv | 23 ++
 rtl/fproc_arbiter_if.sv | 45 ++++
 rtl/rr_pick.sv | 32 +++
 rtl/fproc_arbiter.sv | 133 +++++++++++++
 tb/tb_fproc_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fproc_arb_pkg.sv
// fproc arbiter shared definitions.
// State encoding, error codes and core/fproc widths.
package fproc_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_RESPOND = ST_RESPOND
    } state_t;

    localparam logic ERR_NONE    = 1'b0;
    localparam logic ERR_TIMEOUT = 1'b1;

    localparam int FPROC_ID_WIDTH   = 8;
    localparam int FPROC_DATA_WIDTH = 32;

endpackage

// File: rtl/fproc_arbiter_if.sv
// Core-side and backend-side signals of the fproc arbiter.
// slave = arbiter view, master = cores/backend view.
interface fproc_arbiter_if
    import fproc_arb_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int ID_WIDTH   = FPROC_ID_WIDTH,
    parameter int DATA_WIDTH = FPROC_DATA_WIDTH
);

    logic [N_CORES-1:0]          core_req;
    logic [N_CORES*ID_WIDTH-1:0] core_id;
    logic [N_CORES-1:0]          core_ready;
    logic [DATA_WIDTH-1:0]       core_data;
    logic                        core_err;
    logic                        fproc_req_stb;
    logic [ID_WIDTH-1:0]         fproc_req_id;
    logic                        fproc_resp_valid;
    logic [DATA_WIDTH-1:0]       fproc_resp_data;

    modport slave (
        input  core_req,
        input  core_id,
        input  fproc_resp_valid,
        input  fproc_resp_data,
        output core_ready,
        output core_data,
        output core_err,
        output fproc_req_stb,
        output fproc_req_id
    );

    modport master (
        output core_req,
        output core_id,
        output fproc_resp_valid,
        output fproc_resp_data,
        input  core_ready,
        input  core_data,
        input  core_err,
        input  fproc_req_stb,
        input  fproc_req_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches from last_grant+1 upward, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] grant,
    output logic          any_valid
);

    logic [GW:0] cand;

    // lowest offset from last_grant wins, so scan offsets high to low
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = N; i >= 1; i--) begin
            cand = {1'b0, last_grant} + (GW+1)'(i);
            if (cand >= (GW+1)'(N)) begin
                cand = cand - (GW+1)'(N);
            end
            if (req[cand[GW-1:0]]) begin
                grant     = cand[GW-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one fproc backend among N_CORES cores.
// Latches request pulses, grants round-robin, one transaction at a time.
module fproc_arbiter
    import fproc_arb_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int ID_WIDTH       = FPROC_ID_WIDTH,
    parameter int DATA_WIDTH     = FPROC_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic           clk,
    input logic           reset,
    fproc_arbiter_if.slave bus
);

    localparam int GW = $clog2(N_CORES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(N_CORES - 1);

    state_t state_q;
    state_t state_d;

    logic [N_CORES-1:0]    pending_q;
    logic [N_CORES-1:0]    req_set;
    logic [N_CORES-1:0]    req_clr;
    logic [ID_WIDTH-1:0]   id_q [N_CORES];
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_q;
    logic [GW-1:0]         pick;
    logic                  any_req;
    logic [TW-1:0]         timer_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  time_up;

    rr_pick #(
        .N  (N_CORES),
        .GW (GW)
    ) u_pick (
        .req        (pending_q),
        .last_grant (last_q),
        .grant      (pick),
        .any_valid  (any_req)
    );

    assign req_clr = (state_q == S_RESPOND) ? (N_CORES'(1) << grant_q) : '0;
    // the granted core may re-request in its own RESPOND cycle
    assign req_set = bus.core_req & (~pending_q | req_clr);
    assign time_up = (timer_q == T_LAST);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode; a response beats the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (any_req) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (bus.fproc_resp_valid || time_up) state_d = S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // request capture: first pulse sets pending and latches its id
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~req_clr) | req_set;
            for (int i = 0; i < N_CORES; i++) begin
                if (req_set[i]) begin
                    id_q[i] <= bus.core_id[i*ID_WIDTH +: ID_WIDTH];
                end
            end
        end
    end

    // transaction datapath: grant, timeout timer, captured response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= '0;
            last_q  <= G_LAST;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) grant_q <= pick;
                end
                S_ISSUE: begin
                    timer_q <= '0;
                end
                S_WAIT: begin
                    if (bus.fproc_resp_valid) begin
                        data_q <= bus.fproc_resp_data;
                        err_q  <= ERR_NONE;
                    end else if (time_up) begin
                        data_q <= '0;
                        err_q  <= ERR_TIMEOUT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RESPOND: begin
                    last_q <= grant_q;
                end
                default: begin
                    last_q <= last_q;
                end
            endcase
        end
    end

    assign bus.fproc_req_stb = (state_q == S_ISSUE);
    assign bus.fproc_req_id  = id_q[grant_q];
    assign bus.core_ready    = req_clr;
    assign bus.core_data     = data_q;
    assign bus.core_err      = err_q;

endmodule

// File: tb/tb_fproc_arbiter.sv
// Scoreboard bench for fproc_arbiter.
// Transaction-level round-robin model; monitor checks strobes and completions.
module tb_fproc_arbiter;
    import fproc_arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 8;
    localparam int DW  = 32;
    localparam int T   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fproc_arbiter_if #(.N_CORES(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

    fproc_arbiter #(
        .N_CORES        (N),
        .ID_WIDTH       (IDW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          core;
        logic [DW-1:0] data;
        logic        err;
    } rsp_t;

    rsp_t           rsp_q [$];
    logic [IDW-1:0] iss_q [$];
    rsp_t           mon_e;
    logic [IDW-1:0] mon_id;

    bit             mp [N];
    logic [IDW-1:0] mid [N];
    int             mlast;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s %s", name, what);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mp[i]  = 1'b0;
            mid[i] = '0;
        end
        mlast = N - 1;
    endfunction

    function automatic void model_req(input int c, input logic [IDW-1:0] id);
        if (!mp[c]) begin
            mp[c]  = 1'b1;
            mid[c] = id;
        end
    endfunction

    function automatic int model_pick();
        for (int i = 1; i <= N; i++) begin
            if (mp[(mlast + i) % N]) return (mlast + i) % N;
        end
        return -1;
    endfunction

    function automatic bit model_busy();
        for (int i = 0; i < N; i++) begin
            if (mp[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        bus.core_req         = '0;
        bus.fproc_resp_valid = 1'b0;
        bus.fproc_resp_data  = $urandom;
    endtask

    task automatic drive_req(input int c, input logic [IDW-1:0] id);
        bus.core_req[c]            = 1'b1;
        bus.core_id[c*IDW +: IDW]  = id;
        model_req(c, id);
    endtask

    task automatic wait_stb(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            n++;
            if (bus.fproc_req_stb) got = 1'b1;
        end
    endtask

    // d < 0 picks a random response delay; d >= T means the backend is silent
    task automatic run_txn(input int d_in, input logic [DW-1:0] data_in,
                           input int xcore, output int n, output bit ok);
        int            g;
        int            d;
        bit            got;
        logic [DW-1:0] rd;
        rsp_t          e;
        ok = 1'b0;
        wait_stb(n, got);
        if (!got) begin
            fail("stb_wait", "no fproc_req_stb within 40 cycles");
            model_reset();
            return;
        end
        g = model_pick();
        if (g < 0) return;
        iss_q.push_back(mid[g]);
        if (d_in >= 0) begin
            d  = d_in;
            rd = data_in;
        end else begin
            case ($urandom_range(0, 9))
                0, 1:    d = T;
                2:       d = T - 1;
                default: d = $urandom_range(0, T - 2);
            endcase
            rd = $urandom;
        end
        e.core = g;
        e.data = (d >= T) ? '0 : rd;
        e.err  = (d >= T) ? ERR_TIMEOUT : ERR_NONE;
        rsp_q.push_back(e);
        for (int j = 1; j <= d + 1; j++) begin
            cycle();
            if (j == 1 && xcore >= 0) drive_req(xcore, IDW'($urandom));
            if (j - 1 == d) begin
                bus.fproc_resp_valid = 1'b1;
                bus.fproc_resp_data  = rd;
            end
        end
        mp[g] = 1'b0;
        mlast = g;
        ok    = 1'b1;
    endtask

    // monitor: compare every strobe and completion against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.fproc_req_stb) begin
                    if (iss_q.size() == 0) begin
                        fail("unexpected_stb", "strobe with no expected grant");
                    end else begin
                        mon_id = iss_q.pop_front();
                        check("fproc_req_id", 64'(bus.fproc_req_id), 64'(mon_id));
                    end
                end
                if (bus.core_ready != '0) begin
                    if (rsp_q.size() == 0) begin
                        fail("unexpected_ready", "core_ready with nothing expected");
                    end else begin
                        mon_e = rsp_q.pop_front();
                        check("core_ready", 64'(bus.core_ready),
                              64'(N'(1) << mon_e.core));
                        check("core_data", 64'(bus.core_data), 64'(mon_e.data));
                        check("core_err", 64'(bus.core_err), 64'(mon_e.err));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  ok;
        bit  got;
        int  g;
        int  guard;
        logic [N-1:0] mask;

        bus.core_req         = '0;
        bus.core_id          = '0;
        bus.fproc_resp_valid = 1'b0;
        bus.fproc_resp_data  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.core_ready), 64'd0);
        check("rst_stb", 64'(bus.fproc_req_stb), 64'd0);
        check("rst_id", 64'(bus.fproc_req_id), 64'd0);
        check("rst_data", 64'(bus.core_data), 64'd0);
        check("rst_err", 64'(bus.core_err), 64'd0);
        cycle();
        reset = 1'b1;
        repeat (2) cycle();

        // simultaneous cores 0,1,3; core 0 re-requests during core 1
        cycle();
        drive_req(0, 8'hA0);
        drive_req(1, 8'hA1);
        drive_req(3, 8'hA3);
        run_txn(-1, '0, -1, n, ok);
        run_txn(-1, '0, 0, n, ok);
        run_txn(-1, '0, -1, n, ok);
        run_txn(-1, '0, -1, n, ok);
        repeat (3) cycle();

        // single request latency
        cycle();
        drive_req(2, 8'h15);
        run_txn(0, 32'hDEADBEEF, -1, n, ok);
        check("stb_latency", 64'(n), 64'd2);
        cycle();
        check("ready_latency", 64'(bus.core_ready), 64'b0100);
        repeat (3) cycle();

        // silent backend, stray response after the timeout
        cycle();
        drive_req(1, 8'h33);
        run_txn(T + 2, 32'hCAFE0000, -1, n, ok);
        repeat (3) begin
            cycle();
            check("idle_stb", 64'(bus.fproc_req_stb), 64'd0);
            check("idle_ready", 64'(bus.core_ready), 64'd0);
        end

        // response in the final WAIT cycle
        cycle();
        drive_req(3, 8'h44);
        run_txn(T - 1, 32'h1234, -1, n, ok);
        repeat (3) cycle();

        // duplicate pulse while pending
        cycle();
        drive_req(0, 8'h01);
        cycle();
        drive_req(0, 8'h02);
        run_txn(-1, '0, -1, n, ok);
        repeat (3) cycle();

        // randomized bursts
        for (int ep = 0; ep < 40; ep++) begin
            cycle();
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int c = 0; c < N; c++) begin
                if (mask[c]) drive_req(c, IDW'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                cycle();
                for (int c = 0; c < N; c++) begin
                    if (mask[c]) drive_req(c, IDW'($urandom));
                end
            end
            guard = 0;
            ok    = 1'b1;
            while (model_busy() && guard < 30 && ok) begin
                run_txn(-1, '0,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                        n, ok);
                guard++;
            end
            repeat (2) cycle();
            bus.fproc_resp_valid = 1'b1;
            cycle();
        end
        repeat (3) cycle();

        // reset mid-WAIT; core 1 re-requests in its own RESPOND cycle
        cycle();
        drive_req(1, 8'h51);
        run_txn(0, 32'hA5A50001, -1, n, ok);
        cycle();
        drive_req(1, 8'h61);
        drive_req(2, 8'h62);
        wait_stb(n, got);
        if (!got) begin
            fail("stb_wait", "no strobe before reset test");
        end else begin
            g = model_pick();
            iss_q.push_back(mid[g]);
        end
        cycle();
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.core_ready), 64'd0);
        check("mid_rst_stb", 64'(bus.fproc_req_stb), 64'd0);
        check("mid_rst_id", 64'(bus.fproc_req_id), 64'd0);
        check("mid_rst_data", 64'(bus.core_data), 64'd0);
        check("mid_rst_err", 64'(bus.core_err), 64'd0);
        model_reset();
        cycle();
        reset = 1'b1;
        repeat (5) cycle();
        cycle();
        drive_req(1, 8'h71);
        drive_req(3, 8'h73);
        run_txn(-1, '0, -1, n, ok);
        run_txn(-1, '0, -1, n, ok);

        repeat (10) cycle();
        check("rsp_drained", 64'(rsp_q.size()), 64'd0);
        check("iss_drained", 64'(iss_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
